cache_mesi_directory: RTL

//  Home-side MESI coherence responder: answers cache_mesi_request_t ops from CLIENTS private caches.

---
 rtl/cache_mesi_directory.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/cache_mesi_directory.sv
// Home-side MESI directory: tracks sharers/exclusive owner per line index, multicasts
// downgrade/invalidate snoops, gathers acks and returns the granted coherence state.
module cache_mesi_directory #(
   parameter int CLIENTS     = 4,
   parameter int INDEX_WIDTH = 6,
   localparam int CW         = $clog2(CLIENTS)
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   req_valid,
   output logic                   req_ready,
   input  logic [CW-1:0]          req_client,
   input  logic [INDEX_WIDTH-1:0] req_index,
   input  logic [1:0]             req_op,
   output logic                   resp_valid,
   input  logic                   resp_ready,
   output logic [CW-1:0]          resp_client,
   output logic [1:0]             resp_op,
   output logic [1:0]             resp_state,
   output logic                   resp_dirty,
   output logic                   snoop_valid,
   input  logic                   snoop_ready,
   output logic [CLIENTS-1:0]     snoop_mask,
   output logic [INDEX_WIDTH-1:0] snoop_index,
   output logic [1:0]             snoop_op,
   input  logic                   ack_valid,
   output logic                   ack_ready,
   input  logic [CW-1:0]          ack_client,
   input  logic                   ack_dirty
);

   localparam int Entries = 2 ** INDEX_WIDTH;

   localparam logic [1:0] OpShared        = 2'd0;
   localparam logic [1:0] OpExclusive     = 2'd1;
   localparam logic [1:0] OpExclusiveData = 2'd2;
   localparam logic [1:0] OpEviction      = 2'd3;

   localparam logic [1:0] MesiInvalid   = 2'd0;
   localparam logic [1:0] MesiShared    = 2'd1;
   localparam logic [1:0] MesiExclusive = 2'd2;

   typedef enum logic [2:0] {StIdle, StLookup, StSnoop, StWaitAck, StRespond} state_e;

   state_e                 state;
   logic [CLIENTS-1:0]     dir_sharers [Entries];
   logic [Entries-1:0]     dir_excl;
   logic [CW-1:0]          cur_client;
   logic [INDEX_WIDTH-1:0] cur_index;
   logic [1:0]             cur_op;
   logic [CLIENTS-1:0]     pending;
   logic [CLIENTS-1:0]     upd_sharers;
   logic                   upd_excl;

   logic [CLIENTS-1:0] cbit, rd_sharers, others, lk_mask, lk_sharers, ack_bit, pending_nxt;
   logic               rd_excl, lk_excl, ack_hit;
   logic [1:0]         lk_snoop_op, lk_grant, lk_resp_op;

   always_comb begin
      cbit        = CLIENTS'(1) << cur_client;
      rd_sharers  = dir_sharers[cur_index];
      rd_excl     = dir_excl[cur_index];
      others      = rd_sharers & ~cbit;
      lk_mask     = '0;
      lk_snoop_op = OpEviction;
      lk_sharers  = rd_sharers;
      lk_excl     = rd_excl;
      lk_grant    = MesiInvalid;
      lk_resp_op  = cur_op;
      unique case (cur_op)
         OpShared: begin
            // Only an exclusive owner other than the requester needs a downgrade.
            lk_mask     = rd_excl ? others : '0;
            lk_snoop_op = OpShared;
            lk_sharers  = rd_sharers | cbit;
            lk_excl     = (others == '0);
            lk_grant    = (others == '0) ? MesiExclusive : MesiShared;
         end
         OpExclusive, OpExclusiveData: begin
            lk_mask    = others;
            lk_sharers = cbit;
            lk_excl    = 1'b1;
            lk_grant   = MesiExclusive;
            lk_resp_op = (cur_op == OpExclusive && (rd_sharers & cbit) != '0) ?
                         OpExclusive : OpExclusiveData;
         end
         OpEviction: begin
            // An owner evicting leaves no sharers; a non-owner leaves the owner intact.
            lk_sharers = others;
            lk_excl    = rd_excl && (others != '0);
         end
         default: ;
      endcase
      ack_bit     = CLIENTS'(1) << ack_client;
      ack_hit     = ack_valid && ack_ready && ((pending & ack_bit) != '0);
      pending_nxt = ack_hit ? (pending & ~ack_bit) : pending;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= StIdle;
         req_ready   <= 1'b0;
         resp_valid  <= 1'b0;
         resp_client <= '0;
         resp_op     <= '0;
         resp_state  <= '0;
         resp_dirty  <= 1'b0;
         snoop_valid <= 1'b0;
         snoop_mask  <= '0;
         snoop_index <= '0;
         snoop_op    <= '0;
         ack_ready   <= 1'b0;
         cur_client  <= '0;
         cur_index   <= '0;
         cur_op      <= '0;
         pending     <= '0;
         upd_sharers <= '0;
         upd_excl    <= 1'b0;
         dir_excl    <= '0;
         for (int i = 0; i < Entries; i++) dir_sharers[i] <= '0;
      end else begin
         unique case (state)
            StIdle: begin
               req_ready <= 1'b1;
               if (req_valid && req_ready) begin
                  cur_client <= req_client;
                  cur_index  <= req_index;
                  cur_op     <= req_op;
                  req_ready  <= 1'b0;
                  state      <= StLookup;
               end
            end
            StLookup: begin
               resp_client <= cur_client;
               resp_op     <= lk_resp_op;
               resp_state  <= lk_grant;
               upd_sharers <= lk_sharers;
               upd_excl    <= lk_excl;
               if (lk_mask == '0) begin
                  dir_sharers[cur_index] <= lk_sharers;
                  dir_excl[cur_index]    <= lk_excl;
                  resp_valid             <= 1'b1;
                  state                  <= StRespond;
               end else begin
                  snoop_valid <= 1'b1;
                  snoop_mask  <= lk_mask;
                  snoop_index <= cur_index;
                  snoop_op    <= lk_snoop_op;
                  state       <= StSnoop;
               end
            end
            StSnoop: begin
               if (snoop_ready) begin
                  snoop_valid <= 1'b0;
                  pending     <= snoop_mask;
                  ack_ready   <= 1'b1;
                  state       <= StWaitAck;
               end
            end
            StWaitAck: begin
               pending <= pending_nxt;
               if (ack_hit) resp_dirty <= resp_dirty | ack_dirty;
               if (pending_nxt == '0) begin
                  dir_sharers[cur_index] <= upd_sharers;
                  dir_excl[cur_index]    <= upd_excl;
                  ack_ready              <= 1'b0;
                  resp_valid             <= 1'b1;
                  state                  <= StRespond;
               end
            end
            StRespond: begin
               if (resp_ready) begin
                  resp_valid <= 1'b0;
                  resp_dirty <= 1'b0;
                  req_ready  <= 1'b1;
                  state      <= StIdle;
               end
            end
            default: state <= StIdle;
         endcase
      end
   end

endmodule
